// File: rtl/dht11_poll_scheduler.sv
// DHT11 poll scheduler: periodic/forced starts, timeout, bounded retry, sample latch.
// Optional build macro RANGE_CHECK_EN rejects out-of-range humidity/temperature readings.
module dht11_poll_scheduler #(
    parameter int unsigned POLL_CYC    = 200_000_000,
    parameter int unsigned TIMEOUT_CYC = 10_000_000,
    parameter int unsigned RETRY_CYC   = 120_000_000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned STALE_LIM   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       force_req,
    output logic       meas_start,
    input  logic       meas_done,
    input  logic       meas_err,
    input  logic [7:0] temp_raw,
    input  logic [7:0] hum_raw,
    output logic [7:0] temp,
    output logic [7:0] hum,
    output logic       data_valid,
    output logic       stale,
    output logic [7:0] err_cnt,
    output logic       busy
);

    localparam int unsigned MAX_PT  = (POLL_CYC > TIMEOUT_CYC) ? POLL_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_MAX = (MAX_PT > RETRY_CYC) ? MAX_PT : RETRY_CYC;
    localparam int          CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYC - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] RETRY_LAST = CW'(RETRY_CYC - 1);
    localparam logic [7:0]    MAX_R      = 8'(MAX_RETRY);
    localparam logic [7:0]    STALE_L    = 8'(STALE_LIM);

    typedef enum logic [1:0] {
        S_WAIT,
        S_START,
        S_BUSY,
        S_BACKOFF
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    retry, retry_nx;
    logic [7:0]    fail_cyc, fail_nx;
    logic [7:0]    err_nx, temp_nx, hum_nx;
    logic          dv_nx, stale_nx;
    logic          range_bad, attempt_fail;

`ifdef RANGE_CHECK_EN
    assign range_bad = (hum_raw > 8'd95) || (temp_raw > 8'd60);
`else
    assign range_bad = 1'b0;
`endif

    assign meas_start = (state == S_START);
    assign busy       = (state == S_START) || (state == S_BUSY);

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt + CW'(1);
        retry_nx     = retry;
        fail_nx      = fail_cyc;
        err_nx       = err_cnt;
        temp_nx      = temp;
        hum_nx       = hum;
        dv_nx        = data_valid;
        stale_nx     = stale;
        attempt_fail = 1'b0;
        unique case (state)
            S_WAIT: begin
                if (force_req || cnt == POLL_LAST) begin
                    state_nx = S_START;
                    cnt_nx   = '0;
                end
            end
            S_START: begin
                state_nx = S_BUSY;
                cnt_nx   = '0;
            end
            S_BUSY: begin
                // A done in the timeout cycle is judged on its own merits.
                if (meas_done) begin
                    if (meas_err || range_bad) begin
                        attempt_fail = 1'b1;
                    end else begin
                        temp_nx  = temp_raw;
                        hum_nx   = hum_raw;
                        dv_nx    = 1'b1;
                        stale_nx = 1'b0;
                        fail_nx  = '0;
                        retry_nx = '0;
                        state_nx = S_WAIT;
                        cnt_nx   = '0;
                    end
                end else if (cnt == TO_LAST) begin
                    attempt_fail = 1'b1;
                end
            end
            S_BACKOFF: begin
                if (cnt == RETRY_LAST) begin
                    state_nx = S_START;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = S_WAIT;
        endcase
        if (attempt_fail) begin
            cnt_nx = '0;
            if (err_cnt != 8'hFF) err_nx = err_cnt + 8'd1;
            if (retry < MAX_R) begin
                retry_nx = retry + 8'd1;
                state_nx = S_BACKOFF;
            end else begin
                retry_nx = '0;
                if (fail_cyc != 8'hFF) fail_nx = fail_cyc + 8'd1;
                stale_nx = stale || (fail_nx >= STALE_L);
                state_nx = S_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_WAIT;
            cnt        <= '0;
            retry      <= '0;
            fail_cyc   <= '0;
            err_cnt    <= '0;
            temp       <= '0;
            hum        <= '0;
            data_valid <= 1'b0;
            stale      <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            retry      <= retry_nx;
            fail_cyc   <= fail_nx;
            err_cnt    <= err_nx;
            temp       <= temp_nx;
            hum        <= hum_nx;
            data_valid <= dv_nx;
            stale      <= stale_nx;
        end
    end

endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// Scoreboard bench for dht11_poll_scheduler: scripted reader, start/data monitors.
// Cycle 0 is the cycle in which rst is released.
module tb_dht11_poll_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       force_req = 1'b0;
    logic       meas_start;
    logic       meas_done = 1'b0;
    logic       meas_err = 1'b0;
    logic [7:0] temp_raw = 8'h00;
    logic [7:0] hum_raw = 8'h00;
    logic [7:0] temp, hum, err_cnt;
    logic       data_valid, stale, busy;

    dht11_poll_scheduler #(
        .POLL_CYC(100), .TIMEOUT_CYC(20), .RETRY_CYC(30),
        .MAX_RETRY(3), .STALE_LIM(3)
    ) dut (
        .clk(clk), .rst(rst), .force_req(force_req),
        .meas_start(meas_start), .meas_done(meas_done), .meas_err(meas_err),
        .temp_raw(temp_raw), .hum_raw(hum_raw), .temp(temp), .hum(hum),
        .data_valid(data_valid), .stale(stale), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    typedef struct {
        int         c;
        logic [7:0] t, h, e;
        logic       dv, st;
    } exp_t;

    exp_t q_start[$];
    exp_t q_data[$];
    int   vectors = 0;
    int   errs = 0;
    bit   mon_en = 1'b0;
    int   last_start;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic exp_start(input int c, input logic [7:0] t, h,
                             input logic dv, st, input logic [7:0] e);
        exp_t r;
        r.c = c; r.t = t; r.h = h; r.dv = dv; r.st = st; r.e = e;
        q_start.push_back(r);
    endtask

    task automatic exp_data(input int c, input logic [7:0] t, h, input logic dv, st);
        exp_t r;
        r.c = c; r.t = t; r.h = h; r.dv = dv; r.st = st; r.e = 8'h00;
        q_data.push_back(r);
    endtask

    task automatic done_at(input int c, input logic err, input logic [7:0] t, h);
        goto(c);
        meas_done = 1'b1; meas_err = err; temp_raw = t; hum_raw = h;
        goto(c + 1);
        meas_done = 1'b0; meas_err = 1'b0;
    endtask

    task automatic pulse_force(input int c);
        goto(c);
        force_req = 1'b1;
        goto(c + 1);
        force_req = 1'b0;
    endtask

    initial begin
        logic [7:0] pt, ph;
        logic       pdv, pst;
        repeat (3) @(negedge clk);
        chk("rst_meas_start", 32'(meas_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_temp", 32'(temp), 32'd0);
        chk("rst_hum", 32'(hum), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_stale", 32'(stale), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        pt = temp; ph = hum; pdv = data_valid; pst = stale;
        rst = 1'b1;
        mon_en = 1'b1;
        fork
            begin
                // first poll, good answer
                exp_start(100, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
                exp_data(106, 8'h17, 8'h2D, 1'b1, 1'b0);
                done_at(105, 1'b0, 8'h17, 8'h2D);
                // error then good retry
                exp_start(206, 8'h17, 8'h2D, 1'b1, 1'b0, 8'd0);
                exp_start(242, 8'h17, 8'h2D, 1'b1, 1'b0, 8'd1);
                exp_data(248, 8'h19, 8'h30, 1'b1, 1'b0);
                done_at(211, 1'b1, 8'hAA, 8'hBB);
                done_at(247, 1'b0, 8'h19, 8'h30);
                // silent reader: three give-up cycles of four attempts
                for (int g = 0; g < 3; g++)
                    for (int a = 0; a < 4; a++)
                        exp_start(348 + g * 274 + a * 51, 8'h19, 8'h30,
                                  1'b1, 1'b0, 8'(1 + g * 4 + a));
                exp_data(1070, 8'h19, 8'h30, 1'b1, 1'b1);
                exp_start(1170, 8'h19, 8'h30, 1'b1, 1'b1, 8'd13);
                // done in the timeout cycle wins
                exp_data(1191, 8'h1A, 8'h31, 1'b1, 1'b0);
                done_at(1190, 1'b0, 8'h1A, 8'h31);
                // force in BUSY ignored, stray done in WAIT ignored, force in WAIT
                exp_start(1291, 8'h1A, 8'h31, 1'b1, 1'b0, 8'd13);
                exp_data(1297, 8'h1B, 8'h32, 1'b1, 1'b0);
                pulse_force(1293);
                done_at(1296, 1'b0, 8'h1B, 8'h32);
                done_at(1310, 1'b1, 8'hFF, 8'hFF);
                exp_start(1338, 8'h1B, 8'h32, 1'b1, 1'b0, 8'd13);
                pulse_force(1337);
`ifdef RANGE_CHECK_EN
                done_at(1343, 1'b0, 8'h1C, 8'h63);
                exp_start(1374, 8'h1B, 8'h32, 1'b1, 1'b0, 8'd14);
                exp_data(1380, 8'h1C, 8'h2E, 1'b1, 1'b0);
                done_at(1379, 1'b0, 8'h1C, 8'h2E);
                exp_start(1480, 8'h1C, 8'h2E, 1'b1, 1'b0, 8'd14);
                last_start = 1480;
`else
                exp_data(1344, 8'h1C, 8'h63, 1'b1, 1'b0);
                done_at(1343, 1'b0, 8'h1C, 8'h63);
                exp_start(1444, 8'h1C, 8'h63, 1'b1, 1'b0, 8'd13);
                last_start = 1444;
`endif
                goto(last_start + 2);
                mon_en = 1'b0;
            end
            begin
                while (mon_en) begin
                    @(negedge clk);
                    if (mon_en && meas_start) begin
                        if (q_start.size() == 0) begin
                            chk("unexpected_start_cyc", 32'(cyc), 32'hFFFFFFFF);
                        end else begin
                            exp_t r;
                            r = q_start.pop_front();
                            chk("start_cyc", 32'(cyc), 32'(r.c));
                            chk("start_state", {8'(busy), err_cnt, 6'd0, data_valid, stale, temp, hum},
                                {8'd1, r.e, 6'd0, r.dv, r.st, r.t, r.h});
                        end
                    end
                    if (mon_en && {temp, hum, data_valid, stale} !== {pt, ph, pdv, pst}) begin
                        if (q_data.size() == 0) begin
                            chk("unexpected_data_cyc", 32'(cyc), 32'hFFFFFFFF);
                        end else begin
                            exp_t r;
                            r = q_data.pop_front();
                            chk("data_cyc", 32'(cyc), 32'(r.c));
                            chk("data_vals", {14'd0, data_valid, stale, temp, hum},
                                {14'd0, r.dv, r.st, r.t, r.h});
                        end
                        pt = temp; ph = hum; pdv = data_valid; pst = stale;
                    end
                end
            end
        join
        chk("starts_pending", 32'(q_start.size()), 32'd0);
        chk("data_pending", 32'(q_data.size()), 32'd0);
        chk("busy_before_abort", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_meas_start", 32'(meas_start), 32'd0);
        chk("abort_outputs", {err_cnt, 6'd0, data_valid, stale, temp, hum}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
